// File: rtl/countdown_timer.sv
// Per-player chess clock: M:SS countdown gated by flag, with active-low 7-segment digits and a sticky Timeout.
// Segments and Timeout are combinational from the digit registers; there is no handshake, and flag is sampled every cycle.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int START_MINS    = 5,
  parameter int START_TENS    = 0,
  parameter int START_UNITS   = 0
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       flag,
  output logic [6:0] SegMins,
  output logic [6:0] SegSecTens,
  output logic [6:0] SegSecUnits,
  output logic       Timeout
);

  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    MINS_INIT  = 4'(START_MINS);
  localparam logic [3:0]    TENS_INIT  = 4'(START_TENS);
  localparam logic [3:0]    UNITS_INIT = 4'(START_UNITS);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    mins_q, mins_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          run;
  logic          tick;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign Timeout     = (mins_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);
  assign SegMins     = seg7(mins_q);
  assign SegSecTens  = seg7(tens_q);
  assign SegSecUnits = seg7(units_q);

  // Once at 0:00 the prescaler freezes too, so nothing moves until reset.
  always_comb begin
    run     = flag && !Timeout;
    tick    = run && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    mins_d  = mins_q;
    tens_d  = tens_q;
    units_d = units_q;
    if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      if (units_q != 4'd0) begin
        units_d = units_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        units_d = 4'd9;
        tens_d  = tens_q - 4'd1;
      end else if (mins_q != 4'd0) begin
        units_d = 4'd9;
        tens_d  = 4'd5;
        mins_d  = mins_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      presc_q <= '0;
      mins_q  <= MINS_INIT;
      tens_q  <= TENS_INIT;
      units_q <= UNITS_INIT;
    end else begin
      presc_q <= presc_d;
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Two timers (5:00 and 1:00 start) on a shared clock, checked every edge against a seconds-based reference model.
module tb_countdown_timer;
  localparam int T       = 4;
  localparam int START_A = 300;
  localparam int START_B = 60;

  logic       clock  = 1'b0;
  logic       rst_a  = 1'b0;
  logic       rst_b  = 1'b0;
  logic       flag_a = 1'b0;
  logic       flag_b = 1'b0;
  logic [6:0] seg_m_a, seg_t_a, seg_u_a, seg_m_b, seg_t_b, seg_u_b;
  logic       to_a, to_b;

  always #5 clock = ~clock;

  countdown_timer #(.TICKS_PER_SEC(T)) dut_a (
    .clock(clock), .resetApp(rst_a), .flag(flag_a),
    .SegMins(seg_m_a), .SegSecTens(seg_t_a), .SegSecUnits(seg_u_a), .Timeout(to_a)
  );

  countdown_timer #(.TICKS_PER_SEC(T), .START_MINS(1), .START_TENS(0), .START_UNITS(0)) dut_b (
    .clock(clock), .resetApp(rst_b), .flag(flag_b),
    .SegMins(seg_m_b), .SegSecTens(seg_t_b), .SegSecUnits(seg_u_b), .Timeout(to_b)
  );

  typedef struct {
    logic [21:0] a;
    logic [21:0] b;
    int          phase;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;
  int   a_secs = START_A, a_frac = 0;
  int   b_secs = START_B, b_frac = 0;
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [21:0] expect_of(input int secs);
    logic [3:0] m, t, u;
    m = 4'(secs / 60);
    t = 4'((secs % 60) / 10);
    u = 4'(secs % 10);
    return {seg_tab[m], seg_tab[t], seg_tab[u], secs == 0};
  endfunction

  // One clock edge of a player's clock in terms of whole seconds left plus enabled cycles into the current second.
  task automatic adv(inout int secs, inout int frac, input logic f, input logic r, input int start);
    if (r) begin
      secs = start;
      frac = 0;
    end else if (f && secs > 0) begin
      frac++;
      if (frac == T) begin
        frac = 0;
        secs--;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.a     = expect_of(a_secs);
    e.b     = expect_of(b_secs);
    e.phase = phase;
    sb.push_back(e);
  endtask

  task automatic step(input logic fa, input logic fb, input logic rel_a, input logic rel_b);
    @(negedge clock);
    flag_a = fa;
    flag_b = fb;
    if (rel_a) rst_a = 1'b0;
    if (rel_b) rst_b = 1'b0;
    adv(a_secs, a_frac, fa, rst_a, START_A);
    adv(b_secs, b_frac, fb, rst_b, START_B);
    push_exp();
  endtask

  // Reset lands mid low-phase so its effect is observed before the next rising edge.
  task automatic async_reset(input logic ra, input logic rb);
    @(negedge clock);
    #2;
    if (ra) begin a_secs = START_A; a_frac = 0; end
    if (rb) begin b_secs = START_B; b_frac = 0; end
    push_exp();
    if (ra) rst_a = 1'b1;
    if (rb) rst_b = 1'b1;
    adv(a_secs, a_frac, flag_a, rst_a, START_A);
    adv(b_secs, b_frac, flag_b, rst_b, START_B);
    push_exp();
  endtask

  function automatic logic rnd_flag();
    return ($urandom_range(0, 3) != 0);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock or posedge rst_a or posedge rst_b);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({seg_m_a, seg_t_a, seg_u_a, to_a} !== e.a) begin
          bad++;
          $display("FAIL dut_a phase %0d t=%0t: got seg=%h/%h/%h to=%b want %h", e.phase, $time,
                   seg_m_a, seg_t_a, seg_u_a, to_a, e.a);
        end
        total++;
        if ({seg_m_b, seg_t_b, seg_u_b, to_b} !== e.b) begin
          bad++;
          $display("FAIL dut_b phase %0d t=%0t: got seg=%h/%h/%h to=%b want %h", e.phase, $time,
                   seg_m_b, seg_t_b, seg_u_b, to_b, e.b);
        end
      end
    end
  end

  initial begin : driver
    int n;
    // reset both, hold, release
    phase = 1;
    async_reset(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // first second on A: 5:00 -> 4:59 on the 4th enabled edge
    phase = 2;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // pause keeps the sub-second fraction
    phase = 3;
    for (int i = 0; i < 2; i++)   step(1'b1, rnd_flag(), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, rnd_flag(), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)   step(1'b1, rnd_flag(), 1'b0, 1'b0);

    // B to 0:37, async reset there, then down to 0:00 and beyond
    phase = 4;
    n = 0;
    while (b_secs != 37 && n < 2000) begin step(rnd_flag(), 1'b1, 1'b0, 1'b0); n++; end
    if (b_secs != 37) begin
      total++; bad++;
      $display("FAIL reach_b_0_37: got %0d secs want 37", b_secs);
    end
    async_reset(1'b0, 1'b1);
    step(rnd_flag(), 1'b1, 1'b0, 1'b1);
    phase = 5;
    n = 0;
    while (b_secs != 0 && n < 2000) begin step(rnd_flag(), 1'b1, 1'b0, 1'b0); n++; end
    if (b_secs != 0) begin
      total++; bad++;
      $display("FAIL reach_b_0_00: got %0d secs want 0", b_secs);
    end
    phase = 6;
    for (int i = 0; i < 20; i++) step(rnd_flag(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(rnd_flag(), rnd_flag(), 1'b0, 1'b0);

    // A random run, then to 0:37 and async reset; next tick T cycles after release
    phase = 7;
    for (int i = 0; i < 300; i++) step(rnd_flag(), rnd_flag(), 1'b0, 1'b0);
    n = 0;
    while (a_secs != 37 && n < 3000) begin step(1'b1, rnd_flag(), 1'b0, 1'b0); n++; end
    if (a_secs != 37) begin
      total++; bad++;
      $display("FAIL reach_a_0_37: got %0d secs want 37", a_secs);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    phase = 8;
    async_reset(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rnd_flag(), 1'b0, 1'b0);

    @(posedge clock);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
